// File: rtl/rle_packer.sv
// Run-length packer: coalesces repeated 16-bit values into {value, count} FIFO words.
// Optional idle auto-flush is compiled in when RLE_TIMEOUT_EN is defined.
module rle_packer #(
  parameter int MAX_RUN        = 65535,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  input  logic        flush,
  input  logic        full,
  output logic        enqueue,
  output logic [31:0] data_out,
  output logic        busy
);

  localparam logic [15:0] MAX_CNT = 16'(MAX_RUN);

  logic [15:0] run_val;
  logic [15:0] run_cnt;
  logic        have_run;
  logic        pend;
  logic [31:0] pend_word;
  logic        flush_req;

  logic accept;
  logic slot_free;
  logic extend;
  logic flush_go;
  logic load;
  logic timeout_hit;

  assign slot_free = !pend || !full;
  assign enqueue   = pend && !full;
  assign data_out  = pend_word;
  assign in_ready  = !flush_req && !(pend && full);
  assign busy      = have_run || pend || flush_req;
  assign accept    = in_valid && in_ready;

  // A beat extends the open run only while it matches and the count has headroom.
  assign extend   = have_run && (in_data == run_val) && (run_cnt < MAX_CNT);
  assign flush_go = flush_req && slot_free;
  // accept and flush_go are mutually exclusive, so both close paths load the same word.
  assign load     = have_run && ((accept && !extend) || flush_go);

`ifdef RLE_TIMEOUT_EN
  logic [15:0] idle_cnt;

  assign timeout_hit = have_run && !flush_req && (idle_cnt == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= 16'd0;
    end else if (accept || flush_req || timeout_hit) begin
      idle_cnt <= 16'd0;
    end else if (have_run) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      have_run  <= 1'b0;
      run_cnt   <= 16'd0;
      pend      <= 1'b0;
      pend_word <= 32'd0;
      flush_req <= 1'b0;
    end else begin
      if (load) begin
        pend      <= 1'b1;
        pend_word <= {run_val, run_cnt};
      end else if (enqueue) begin
        pend      <= 1'b0;
        pend_word <= 32'd0;
      end

      if (accept) begin
        have_run <= 1'b1;
        if (extend) begin
          run_cnt <= run_cnt + 16'd1;
        end else begin
          run_val <= in_data;
          run_cnt <= 16'd1;
        end
      end else if (flush_go) begin
        have_run <= 1'b0;
      end

      // A new request arriving on the clearing edge re-arms flush_req.
      if (flush || timeout_hit) begin
        flush_req <= 1'b1;
      end else if (flush_go) begin
        flush_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rle_packer.sv
// Self-checking bench for rle_packer: directed scenarios plus randomized traffic
// compared against a run-length reference computed from the accepted-beat stream.
module tb_rle_packer;

  localparam int MAXR = 4;
  localparam int TOUT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        flush;
  logic        full;
  logic        enqueue;
  logic [31:0] data_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int          tok[$];
  logic [31:0] got[$];
  logic [31:0] exp_q[$];

  rle_packer #(.MAX_RUN(MAXR), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .full(full), .enqueue(enqueue),
    .data_out(data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Record accepted beats, flush requests (marker -1) and emitted words.
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) tok.push_back(int'(in_data));
      if (flush) tok.push_back(-1);
      if (enqueue) got.push_back(data_out);
    end
  end

  // Reference: run-length encode the token stream, closing runs on a value change,
  // on reaching MAXR, or at a flush marker.
  function automatic void build_exp();
    int mv, mc;
    bit mh;
    exp_q.delete();
    mh = 0; mv = 0; mc = 0;
    foreach (tok[i]) begin
      if (tok[i] < 0) begin
        if (mh) exp_q.push_back({mv[15:0], mc[15:0]});
        mh = 0;
      end else if (!mh) begin
        mv = tok[i]; mc = 1; mh = 1;
      end else if (tok[i] == mv && mc < MAXR) begin
        mc++;
      end else begin
        exp_q.push_back({mv[15:0], mc[15:0]});
        mv = tok[i]; mc = 1;
      end
    end
  endfunction

  task automatic drive(input logic v, input logic [15:0] d, input logic f);
    in_valid = v; in_data = d; flush = f;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic settle(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    tok.delete(); got.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 16'd0; flush = 1'b0; full = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (enqueue !== 1'b0 || data_out !== 32'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: enq=%b dout=%h rdy=%b busy=%b, required 0 0 1 0",
               enqueue, data_out, in_ready, busy);
    end
    @(posedge clk); #1;
    clear_logs();
  endtask

  task automatic test_basic();
    bit ok;
    int sum;
    clear_logs();
    drive(1, 16'd5, 0); drive(1, 16'd5, 0); drive(1, 16'd5, 0); drive(1, 16'd7, 0);
    drive(0, 16'd0, 1);
    settle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_settle: busy stuck at 1, required 0"); end
    checks++;
    if (got.size() != 2 || got[0] !== 32'h00050003 || got[1] !== 32'h00070001) begin
      errors++;
      $display("FAIL basic_words: got %0d words first=%h, required 2 words 00050003,00070001",
               got.size(), (got.size() > 0) ? got[0] : 32'hx);
    end
    sum = 0;
    foreach (got[i]) sum += int'(got[i][15:0]);
    checks++;
    if (sum != 4) begin errors++; $display("FAIL basic_sum: %0d, required 4", sum); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: %b, required 0", busy); end
  endtask

  task automatic test_saturation();
    bit ok;
    clear_logs();
    repeat (6) drive(1, 16'd9, 0);
    drive(0, 16'd0, 1);
    settle(ok);
    build_exp();
    checks++;
    if (!ok || got.size() != exp_q.size() || got.size() != 2) begin
      errors++;
      $display("FAIL sat_count: %0d words, required %0d (ok=%0d)", got.size(), exp_q.size(), ok);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL sat_word%0d: %h, required %h", i, got[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    clear_logs();
    full = 1'b1;
    drive(1, 16'd1, 0);
    drive(1, 16'd2, 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (enqueue !== 1'b0 || in_ready !== 1'b0 || data_out !== 32'h00010001) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d bad cycles (enq=%b rdy=%b dout=%h), required 0",
               bad, enqueue, in_ready, data_out);
    end
    full = 1'b0;
    @(negedge clk);
    checks++;
    if (enqueue !== 1'b1 || data_out !== 32'h00010001) begin
      errors++;
      $display("FAIL bp_release: enq=%b dout=%h, required 1 00010001", enqueue, data_out);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready: %b, required 1", in_ready); end
    drive(0, 16'd0, 1);
    settle(ok);
    checks++;
    if (got.size() != 2 || got[0] !== 32'h00010001 || got[1] !== 32'h00020001) begin
      errors++;
      $display("FAIL bp_words: %0d words, required 00010001 then 00020001", got.size());
    end
  endtask

  task automatic test_reset_discard();
    clear_logs();
    drive(1, 16'd4, 0); drive(1, 16'd4, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_logs();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || data_out !== 32'd0) begin
      errors++;
      $display("FAIL rst_discard_state: rdy=%b busy=%b dout=%h, required 1 0 0",
               in_ready, busy, data_out);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (got.size() != 0) begin
      errors++;
      $display("FAIL rst_discard_enq: %0d words, required 0", got.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_empty();
    bit ok;
    clear_logs();
    drive(0, 16'd0, 1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty_req: busy=%b rdy=%b, required 1 0", busy, in_ready);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_empty_drop: busy=%b, required 0", busy); end
    repeat (5) @(negedge clk);
    checks++;
    if (got.size() != 0) begin errors++; $display("FAIL flush_empty_enq: %0d words, required 0", got.size()); end
    @(posedge clk); #1;
    drive(1, 16'd6, 1);
    settle(ok);
    checks++;
    if (!ok || got.size() != 1 || got[0] !== 32'h00060001) begin
      errors++;
      $display("FAIL flush_with_beat: %0d words first=%h, required 1 word 00060001",
               got.size(), (got.size() > 0) ? got[0] : 32'hx);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int lat;
    clear_logs();
    drive(1, 16'd3, 0);
`ifdef RLE_TIMEOUT_EN
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (got.size() == 0 && enqueue) begin lat = i; break; end
    end
    checks++;
    if (lat < 8 || lat > 12 || data_out !== 32'h00030001) begin
      errors++;
      $display("FAIL timeout_flush: latency %0d word %h, required 8..12 and 00030001", lat, data_out);
    end
    @(posedge clk); #1;
    settle(ok);
`else
    lat = 0;
    repeat (40) @(negedge clk);
    checks++;
    if (got.size() != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL no_timeout: %0d words busy=%b, required 0 words busy=1", got.size(), busy);
    end
    @(posedge clk); #1;
    drive(0, 16'd0, 1);
    settle(ok);
    checks++;
    if (!ok || got.size() != 1 || got[0] !== 32'h00030001) begin
      errors++;
      $display("FAIL no_timeout_flush: %0d words, required 1 word 00030001 (lat=%0d)", got.size(), lat);
    end
`endif
  endtask

  task automatic test_random();
    bit ok;
    bit prev_blocked;
    logic [31:0] prev_out;
    int unstable, sum, beats, badcnt, mism;
    clear_logs();
    prev_blocked = 0; prev_out = 32'd0; unstable = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(9) < 8);
      in_data  = 16'($urandom_range(2));
      full     = ($urandom_range(9) < 2);
      flush    = ($urandom_range(24) == 0);
      @(negedge clk);
      if (prev_blocked && data_out !== prev_out) unstable++;
      prev_blocked = (data_out != 32'd0) && full;
      prev_out = data_out;
      @(posedge clk); #1;
    end
    full = 1'b0;
    drive(0, 16'd0, 1);
    settle(ok);
    build_exp();
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL rand_stable: %0d changes while blocked, required 0", unstable); end
    checks++;
    if (!ok || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: %0d words, required %0d (ok=%0d)", got.size(), exp_q.size(), ok);
    end
    mism = 0; sum = 0; badcnt = 0; beats = 0;
    foreach (got[i]) begin
      if (i < exp_q.size() && got[i] !== exp_q[i]) mism++;
      sum += int'(got[i][15:0]);
      if (got[i][15:0] == 16'd0 || int'(got[i][15:0]) > MAXR) badcnt++;
    end
    foreach (tok[i]) if (tok[i] >= 0) beats++;
    checks++;
    if (mism != 0) begin errors++; $display("FAIL rand_words: %0d mismatching words, required 0", mism); end
    checks++;
    if (sum != beats) begin errors++; $display("FAIL rand_sum: %0d, required %0d", sum, beats); end
    checks++;
    if (badcnt != 0) begin errors++; $display("FAIL rand_cnt_range: %0d bad counts, required 0", badcnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_reset_discard();
    test_flush_empty();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
